down_sampler: RTL and testbench

DOWN_SAMPLER -- requirements
Module: down_sampler

---
 rtl/down_sampler.sv | 121 ++++++++++++
 tb/tb_down_sampler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/down_sampler.sv
// 2x2 box-average decimator: raster pixels in, one rounded average per 2x2 block out.
// Latency: one cycle from the accept of a block's bottom-right pixel to dout/valid_out.
// Never backpressures; state advances only on valid & ~empty, so stalls just add delay.
module down_sampler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] din,
    input  logic       empty,
    output logic [7:0] dout,
    output logic       valid_out,
    output logic       frame_done
);

    localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int HALF = WIDTH / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    hold;
    logic [8:0]    linebuf [HALF];

    logic          accept;
    logic          col_odd;
    logic          col_last;
    logic          row_last;
    logic          block_out;
    logic          lb_write;
    logic [AW-1:0] lb_addr;
    logic [8:0]    pair_sum;
    logic [9:0]    total;
    logic [7:0]    avg;

    assign accept   = valid & ~empty;
    assign col_odd  = col[0];
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign lb_addr  = AW'(col >> 1);

    assign pair_sum  = {1'b0, hold} + {1'b0, din};
    assign total     = {1'b0, linebuf[lb_addr]} + {1'b0, pair_sum};
    // +2 before the divide by four gives round-half-up; 4*255+2 still fits 10 bits.
    assign avg       = 8'((total + 10'd2) >> 2);

    assign block_out = accept & col_odd & (state == ODD_ROW);
    assign lb_write  = accept & col_odd & (state == EVEN_ROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EVEN_ROW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept && col_last) begin
            if (row_last || state == ODD_ROW) begin
                state_next = EVEN_ROW;
            end else begin
                state_next = ODD_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            hold <= 8'h00;
        end else if (accept) begin
            if (!col_odd) begin
                hold <= din;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Every entry is rewritten on the even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && lb_write) begin
            linebuf[lb_addr] <= pair_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= 8'h00;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= block_out;
            frame_done <= block_out & col_last & row_last;
            if (block_out) begin
                dout <= avg;
            end
        end
    end

endmodule

// File: tb/tb_down_sampler.sv
// Directed bench for down_sampler (4x4 frames) with a queue scoreboard fed by a pixel model.
module tb_down_sampler;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       valid_out;
    logic       frame_done;

    always #5 clk = ~clk;

    down_sampler #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .din        (din),
        .empty      (empty),
        .dout       (dout),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] dat;
        logic       fd;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] obs_dat[$];
    int         obs_acc[$];
    int         obs_fd_cnt = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_seen = 0;
    bit rst_q = 1'b1;
    int mcol = 0;
    int mrow = 0;
    logic [7:0] img [H][W];
    logic [7:0] last_dout = 8'h00;
    bit emp_ph = 1'b0;

    logic [7:0] ramp_exp [4] = '{8'h03, 8'h05, 8'h0b, 8'h0d};
    int         cc_idx [4]   = '{6, 8, 14, 16};
    logic [7:0] pat [4][4]   = '{'{8'd0, 8'd0, 8'd1, 8'd1},
                                 '{8'd1, 8'd0, 8'd0, 8'd0},
                                 '{8'd2, 8'd0, 8'd0, 8'd0},
                                 '{8'd255, 8'd255, 8'd255, 8'd255}};
    logic [7:0] rnd_exp [4]  = '{8'h01, 8'h00, 8'h01, 8'hff};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] avg4(input int a, input int b, input int c, input int d);
        return 8'((a + b + c + d + 2) / 4);
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        if (valid && !empty && !rst) acc_seen <= acc_seen + 1;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_valid_out", valid_out, 0);
            chk("rst_dout", dout, 8'h00);
            chk("rst_frame_done", frame_done, 0);
            last_dout = 8'h00;
        end else if (valid_out) begin
            chk("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("sb_dout", dout, x.dat);
                chk("sb_frame_done", frame_done, x.fd);
                chk("sb_latency_cycle", cyc, x.due);
            end
            obs_dat.push_back(dout);
            obs_acc.push_back(acc_seen);
            if (frame_done) obs_fd_cnt++;
            last_dout = dout;
        end else begin
            chk("dout_hold", dout, last_dout);
            chk("frame_done_alone", frame_done, 0);
        end
    end

    task automatic drive(input logic v, input logic e, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        valid = v;
        empty = e;
        din   = d;
        rst   = r;
        if (r) begin
            mcol = 0;
            mrow = 0;
        end else if (v && !e) begin
            img[mrow][mcol] = d;
            if (mrow[0] && mcol[0]) begin
                exp_t x;
                x.dat = avg4(img[mrow-1][mcol-1], img[mrow-1][mcol], img[mrow][mcol-1], img[mrow][mcol]);
                x.fd  = (mrow == H - 1) && (mcol == W - 1);
                x.due = cyc + 1;
                sb.push_back(x);
            end
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_stalled(input logic [7:0] d);
        logic e;
        logic v;
        for (int i = 0; i < 40; i++) begin
            e = emp_ph;
            emp_ph = ~emp_ph;
            v = 1'($urandom_range(0, 1));
            if (i >= 30) begin
                v = 1'b1;
                e = 1'b0;
            end
            drive(v, e, (v && !e) ? d : 8'($urandom), 1'b0);
            if (v && !e) break;
        end
    endtask

    task automatic clear_obs();
        obs_dat.delete();
        obs_acc.delete();
        obs_fd_cnt = 0;
    endtask

    task automatic check_ramp(input string tag, input int frames);
        idle(3);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        chk({tag, "_count"}, obs_dat.size(), 4 * frames);
        for (int i = 0; i < obs_dat.size() && i < 4 * frames; i++) begin
            chk({tag, "_value"}, obs_dat[i], ramp_exp[i % 4]);
        end
        chk({tag, "_frame_done_count"}, obs_fd_cnt, frames);
    endtask

    initial begin
        int base;

        drive(1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        idle(1);
        @(negedge clk);
        chk("reset_dout", dout, 8'h00);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_frame_done", frame_done, 0);

        // constant frame: outputs after accepts 6, 8, 14, 16
        clear_obs();
        base = acc_seen;
        for (int i = 0; i < 16; i++) send(8'hcc);
        idle(3);
        chk("const_sb_drained", sb.size(), 0);
        chk("const_count", obs_dat.size(), 4);
        for (int i = 0; i < obs_dat.size() && i < 4; i++) begin
            chk("const_value", obs_dat[i], 8'hcc);
            chk("const_accept_index", obs_acc[i] - base, cc_idx[i]);
        end
        chk("const_frame_done_count", obs_fd_cnt, 1);

        // rounding: pattern in the top-left block, zeros elsewhere
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    send((r < 2 && c < 2) ? pat[k][r * 2 + c] : 8'h00);
            idle(3);
            chk("round_count", obs_dat.size(), 4);
            if (obs_dat.size() > 0) chk("round_value", obs_dat[0], rnd_exp[k]);
        end

        // ramp with stalls
        clear_obs();
        for (int i = 0; i < 16; i++) send_stalled(8'(i));
        check_ramp("stall", 1);

        // reset after 6 accepts, then a clean ramp
        for (int i = 0; i < 6; i++) send(8'(i + 100));
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
        @(negedge clk);
        chk("vo_after_rst", valid_out, 0);
        chk("dout_after_rst", dout, 8'h00);
        idle(2);
        clear_obs();
        for (int i = 0; i < 16; i++) send(8'(i));
        check_ramp("midrst", 1);

        // two ramp frames back to back
        clear_obs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send(8'(i));
        check_ramp("b2b", 2);

        // reset together with an accept drops the pixel
        for (int i = 0; i < 3; i++) send(8'(i + 50));
        drive(1'b1, 1'b0, 8'h63, 1'b1);
        clear_obs();
        base = acc_seen;
        for (int i = 0; i < 16; i++) send(8'(i));
        idle(3);
        if (obs_acc.size() > 0) chk("simul_first_index", obs_acc[0] - base, 6);
        chk("simul_count", obs_dat.size(), 4);
        for (int i = 0; i < obs_dat.size() && i < 4; i++)
            chk("simul_value", obs_dat[i], ramp_exp[i]);
        chk("simul_frame_done_count", obs_fd_cnt, 1);
        chk("simul_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
